// File: rtl/pic_ack_sequencer.sv
// 8259-style interrupt-acknowledge sequencer: priority resolution, INTA handshake, ISR and OCW2.
// Define PIC_ACK_TIMEOUT_EN to abandon a sequence that stalls in the INTA gap.
module pic_ack_sequencer #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] irr_req,
   input  logic       inta_n,
   input  logic [4:0] vector_base,
   input  logic       auto_eoi,
   input  logic [7:0] ocw2,
   input  logic       ocw2_wr,
   output logic       int_out,
   output logic [7:0] irr_clear,
   output logic [7:0] isr,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic [2:0] lowest_prio
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_REQ  = 3'd1;
   localparam logic [2:0] ST_ACK1 = 3'd2;
   localparam logic [2:0] ST_GAP  = 3'd3;
   localparam logic [2:0] ST_ACK2 = 3'd4;

   // Rank 0 is the level just above the lowest-priority one.
   function automatic logic [2:0] f_rank(input logic [2:0] lvl, input logic [2:0] lp);
      return lvl - lp - 3'd1;
   endfunction

   // Walk from lowest to highest rank so the highest-ranked set bit wins.
   function automatic logic [2:0] f_top(input logic [7:0] vec, input logic [2:0] lp);
      logic [2:0] lvl;
      logic [2:0] top;
      top = 3'd0;
      for (int r = 7; r >= 0; r--) begin
         lvl = lp + 3'd1 + 3'(r);
         if (vec[lvl]) top = lvl;
      end
      return top;
   endfunction

   logic [SYNC_STAGES-1:0] r_inta_sync;
   logic                   r_inta_prev;
   logic                   w_inta_s;
   logic                   w_inta_fall;
   logic                   w_inta_rise;

   logic [2:0] r_state;
   logic [2:0] w_state_d;
   logic [2:0] r_lvl;
   logic [2:0] w_lvl_d;
   logic       r_spur;
   logic       w_spur_d;
   logic       r_rot_aeoi;
   logic       w_rot_aeoi_d;
   logic       r_int_out;
   logic [7:0] r_irr_clear;
   logic [7:0] w_irr_clear_d;
   logic [7:0] r_isr;
   logic [7:0] w_isr_d;
   logic [7:0] r_data_out;
   logic [7:0] w_data_out_d;
   logic       r_data_oe;
   logic       w_data_oe_d;
   logic [2:0] r_lowest_prio;
   logic [2:0] w_lowest_prio_d;

   logic [2:0] w_req_lvl;
   logic [2:0] w_isr_lvl;
   logic       w_eligible;
   logic [7:0] w_fsm_set;
   logic [7:0] w_fsm_clr;
   logic [7:0] w_eoi_clr;
   logic       w_aeoi_rot;
   logic       w_ocw_rot;
   logic [2:0] w_ocw_lp;
   logic       w_timeout;
   logic       w_unused_ocw2;

   assign w_unused_ocw2 = ^ocw2[4:3];

   assign w_inta_s    = r_inta_sync[SYNC_STAGES-1];
   assign w_inta_fall = r_inta_prev & ~w_inta_s;
   assign w_inta_rise = ~r_inta_prev & w_inta_s;

   assign w_req_lvl  = f_top(irr_req, r_lowest_prio);
   assign w_isr_lvl  = f_top(r_isr, r_lowest_prio);
   assign w_eligible = (irr_req != 8'h00) &&
                       ((r_isr == 8'h00) ||
                        (f_rank(w_req_lvl, r_lowest_prio) < f_rank(w_isr_lvl, r_lowest_prio)));

`ifdef PIC_ACK_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TO_W-1:0] r_to_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
      end else if (r_state != ST_GAP) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
   assign w_timeout        = 1'b0;
`endif

   always_comb begin
      w_state_d     = r_state;
      w_lvl_d       = r_lvl;
      w_spur_d      = r_spur;
      w_data_oe_d   = r_data_oe;
      w_data_out_d  = r_data_out;
      w_irr_clear_d = 8'h00;
      w_fsm_set     = 8'h00;
      w_fsm_clr     = 8'h00;
      w_aeoi_rot    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_eligible) w_state_d = ST_REQ;
         end
         ST_REQ: begin
            // INT stays up even if eligibility drops; an empty IRR yields a spurious IR7 cycle.
            if (w_inta_fall) begin
               w_state_d = ST_ACK1;
               if (irr_req == 8'h00) begin
                  w_lvl_d  = 3'd7;
                  w_spur_d = 1'b1;
               end else begin
                  w_lvl_d       = w_req_lvl;
                  w_spur_d      = 1'b0;
                  w_fsm_set     = 8'h01 << w_req_lvl;
                  w_irr_clear_d = 8'h01 << w_req_lvl;
               end
            end
         end
         ST_ACK1: begin
            if (w_inta_rise) w_state_d = ST_GAP;
         end
         ST_GAP: begin
            if (w_inta_fall) begin
               w_state_d    = ST_ACK2;
               w_data_out_d = {vector_base, r_lvl};
               w_data_oe_d  = 1'b1;
            end else if (w_timeout) begin
               w_state_d = ST_IDLE;
               if (!r_spur) w_fsm_clr = 8'h01 << r_lvl;
            end
         end
         ST_ACK2: begin
            if (w_inta_rise) begin
               w_state_d   = ST_IDLE;
               w_data_oe_d = 1'b0;
               if (auto_eoi && !r_spur) begin
                  w_fsm_clr  = 8'h01 << r_lvl;
                  w_aeoi_rot = r_rot_aeoi;
               end
            end
         end
         default: begin
            w_state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_eoi_clr    = 8'h00;
      w_ocw_rot    = 1'b0;
      w_ocw_lp     = r_lowest_prio;
      w_rot_aeoi_d = r_rot_aeoi;
      if (ocw2_wr) begin
         case (ocw2[7:5])
            3'b001: begin
               if (r_isr != 8'h00) w_eoi_clr = 8'h01 << w_isr_lvl;
            end
            3'b011: begin
               w_eoi_clr = 8'h01 << ocw2[2:0];
            end
            3'b101: begin
               if (r_isr != 8'h00) begin
                  w_eoi_clr = 8'h01 << w_isr_lvl;
                  w_ocw_rot = 1'b1;
                  w_ocw_lp  = w_isr_lvl;
               end
            end
            3'b111: begin
               w_eoi_clr = 8'h01 << ocw2[2:0];
               w_ocw_rot = 1'b1;
               w_ocw_lp  = ocw2[2:0];
            end
            3'b110: begin
               w_ocw_rot = 1'b1;
               w_ocw_lp  = ocw2[2:0];
            end
            3'b100: w_rot_aeoi_d = 1'b1;
            3'b000: w_rot_aeoi_d = 1'b0;
            default: ;
         endcase
      end
   end

   // EOI clears apply before the acknowledge set, so a same-cycle set of that bit survives.
   assign w_isr_d = (r_isr & ~w_eoi_clr & ~w_fsm_clr) | w_fsm_set;

   always_comb begin
      w_lowest_prio_d = r_lowest_prio;
      if (w_ocw_rot) begin
         w_lowest_prio_d = w_ocw_lp;
      end else if (w_aeoi_rot) begin
         w_lowest_prio_d = r_lvl;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inta_sync   <= '1;
         r_inta_prev   <= 1'b1;
         r_state       <= ST_IDLE;
         r_lvl         <= 3'd0;
         r_spur        <= 1'b0;
         r_rot_aeoi    <= 1'b0;
         r_int_out     <= 1'b0;
         r_irr_clear   <= 8'h00;
         r_isr         <= 8'h00;
         r_data_out    <= 8'h00;
         r_data_oe     <= 1'b0;
         r_lowest_prio <= 3'd7;
      end else begin
         r_inta_sync   <= {r_inta_sync[SYNC_STAGES-2:0], inta_n};
         r_inta_prev   <= w_inta_s;
         r_state       <= w_state_d;
         r_lvl         <= w_lvl_d;
         r_spur        <= w_spur_d;
         r_rot_aeoi    <= w_rot_aeoi_d;
         r_int_out     <= (w_state_d == ST_REQ);
         r_irr_clear   <= w_irr_clear_d;
         r_isr         <= w_isr_d;
         r_data_out    <= w_data_out_d;
         r_data_oe     <= w_data_oe_d;
         r_lowest_prio <= w_lowest_prio_d;
      end
   end

   assign int_out     = r_int_out;
   assign irr_clear   = r_irr_clear;
   assign isr         = r_isr;
   assign data_out    = r_data_out;
   assign data_oe     = r_data_oe;
   assign lowest_prio = r_lowest_prio;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Randomized bench for pic_ack_sequencer against a transaction-level 8259 priority/ISR model.
module tb_pic_ack_sequencer;

   localparam int LAT = 3;  // synchroniser depth + edge register

   logic       clk;
   logic       rst_n;
   logic [7:0] irr_req;
   logic       inta_n;
   logic [4:0] vector_base;
   logic       auto_eoi;
   logic [7:0] ocw2;
   logic       ocw2_wr;
   logic       int_out;
   logic [7:0] irr_clear;
   logic [7:0] isr;
   logic [7:0] data_out;
   logic       data_oe;
   logic [2:0] lowest_prio;

   int         n_checks = 0;
   int         n_fails  = 0;

   logic [7:0] m_isr;
   logic [7:0] m_irr;
   int         m_lp;
   bit         m_rot;
   bit         m_req;
   logic [7:0] obs_dout;

   pic_ack_sequencer u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .irr_req     (irr_req),
      .inta_n      (inta_n),
      .vector_base (vector_base),
      .auto_eoi    (auto_eoi),
      .ocw2        (ocw2),
      .ocw2_wr     (ocw2_wr),
      .int_out     (int_out),
      .irr_clear   (irr_clear),
      .isr         (isr),
      .data_out    (data_out),
      .data_oe     (data_oe),
      .lowest_prio (lowest_prio)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int rank(input int n);
      return ((n - m_lp - 1) % 8 + 8) % 8;
   endfunction

   function automatic int top_lvl(input logic [7:0] v);
      int best;
      best = -1;
      for (int n = 0; n < 8; n++) begin
         if (v[n] && (best < 0 || rank(n) < rank(best))) best = n;
      end
      return best;
   endfunction

   function automatic bit eligible();
      if (m_irr == 8'h00) return 1'b0;
      if (m_isr == 8'h00) return 1'b1;
      return rank(top_lvl(m_irr)) < rank(top_lvl(m_isr));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_isr = 8'h00;
      m_irr = 8'h00;
      m_lp  = 7;
      m_rot = 1'b0;
      m_req = 1'b0;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      irr_req  = 8'h00;
      inta_n   = 1'b1;
      ocw2     = 8'h00;
      ocw2_wr  = 1'b0;
      auto_eoi = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      model_reset();
   endtask

   task automatic model_ocw(input logic [7:0] cmd);
      int l;
      l = int'(cmd[2:0]);
      case (cmd[7:5])
         3'b001: if (m_isr != 8'h00) m_isr[top_lvl(m_isr)] = 1'b0;
         3'b011: m_isr[l] = 1'b0;
         3'b101: if (m_isr != 8'h00) begin
            m_lp = top_lvl(m_isr);
            m_isr[m_lp] = 1'b0;
         end
         3'b111: begin
            m_isr[l] = 1'b0;
            m_lp = l;
         end
         3'b110: m_lp = l;
         3'b100: m_rot = 1'b1;
         3'b000: m_rot = 1'b0;
         default: ;
      endcase
   endtask

   task automatic send_ocw(input logic [7:0] cmd);
      ocw2    = cmd;
      ocw2_wr = 1'b1;
      tick();
      ocw2_wr = 1'b0;
      model_ocw(cmd);
      check_val("ocw_isr", isr, m_isr);
      check_val("ocw_lp", lowest_prio, m_lp);
   endtask

   // Full two-pulse acknowledge; optionally empties IRR first or issues a same-cycle specific EOI.
   task automatic do_ack(input bit force_spur, input bit eoi_same);
      int         lvl;
      bit         spur;
      logic [7:0] bm;
      if (force_spur) begin
         m_irr   = 8'h00;
         irr_req = 8'h00;
      end
      spur = (m_irr == 8'h00);
      lvl  = spur ? 7 : top_lvl(m_irr);
      bm   = 8'h01 << lvl;
      inta_n = 1'b0;
      tick();
      tick();
      if (eoi_same) begin
         ocw2    = {3'b011, 2'b00, 3'(lvl)};
         ocw2_wr = 1'b1;
      end
      tick();
      ocw2_wr = 1'b0;
      if (eoi_same) m_isr &= ~bm;
      check_val("irr_clear", irr_clear, spur ? 8'h00 : bm);
      if (!spur) begin
         m_isr  |= bm;
         m_irr  &= ~bm;
         irr_req = m_irr;
      end
      check_val("ack_isr", isr, m_isr);
      tick();
      check_val("irr_clear_end", irr_clear, 8'h00);
      inta_n = 1'b1;
      repeat (LAT + 1) tick();
      check_val("gap_int", int_out, 1'b0);
      check_val("gap_oe", data_oe, 1'b0);
      inta_n = 1'b0;
      repeat (LAT) tick();
      check_val("ack2_oe", data_oe, 1'b1);
      obs_dout = data_out;
      check_val("vector", data_out, {vector_base, 3'(lvl)});
      inta_n = 1'b1;
      repeat (LAT) tick();
      check_val("end_oe", data_oe, 1'b0);
      if (auto_eoi && !spur) begin
         m_isr &= ~bm;
         if (m_rot) m_lp = lvl;
      end
      check_val("end_isr", isr, m_isr);
      check_val("end_lp", lowest_prio, m_lp);
      m_req = 1'b0;
   endtask

   task automatic settle(input bit allow_spur);
      for (int k = 0; k < 16; k++) begin
         tick();
         tick();
         if (!m_req) m_req = eligible();
         check_val("int_out", int_out, m_req);
         if (!m_req) return;
         do_ack(allow_spur && ($urandom_range(0, 7) == 0), 1'b0);
      end
   endtask

   task automatic raise(input logic [7:0] bits);
      m_irr  |= bits;
      irr_req = m_irr;
   endtask

   initial begin
      vector_base = 5'h08;
      do_reset();
      check_val("rst_int", int_out, 1'b0);
      check_val("rst_irrclr", irr_clear, 8'h00);
      check_val("rst_isr", isr, 8'h00);
      check_val("rst_dout", data_out, 8'h00);
      check_val("rst_oe", data_oe, 1'b0);
      check_val("rst_lp", lowest_prio, 3'd7);

      // Ordering: IR2 beats IR5 at reset priority
      raise(8'h24);
      tick();
      tick();
      m_req = eligible();
      check_val("order_int", int_out, 1'b1);
      do_ack(1'b0, 1'b0);
      check_val("order_isr", isr, 8'h04);
      check_val("order_vec", obs_dout, 8'h42);
      settle(1'b0);

      // Nesting: IR3 blocked by IR2 in service, IR0 preempts
      raise(8'h08);
      settle(1'b0);
      check_val("nest_block", int_out, 1'b0);
      raise(8'h01);
      settle(1'b0);
      check_val("nest_isr", isr, 8'h05);

      // AEOI with rotation
      do_reset();
      auto_eoi = 1'b1;
      send_ocw(8'h80);
      raise(8'h10);
      settle(1'b0);
      check_val("aeoi_isr", isr, 8'h00);
      check_val("aeoi_lp", lowest_prio, 3'd4);
      raise(8'h11);
      tick();
      tick();
      m_req = eligible();
      check_val("aeoi_int", int_out, 1'b1);
      do_ack(1'b0, 1'b0);
      check_val("aeoi_lvl0", obs_dout[2:0], 3'd0);
      settle(1'b0);

      // Specific EOI + rotate
      do_reset();
      raise(8'h40);
      settle(1'b0);
      check_val("e6_pre", isr, 8'h40);
      send_ocw(8'hE6);
      check_val("e6_isr", isr, 8'h00);
      check_val("e6_lp", lowest_prio, 3'd6);
      raise(8'h81);
      tick();
      tick();
      m_req = eligible();
      check_val("e6_int", int_out, 1'b1);
      do_ack(1'b0, 1'b0);
      check_val("e6_lvl7", obs_dout[2:0], 3'd7);
      settle(1'b0);

      // Spurious: request withdrawn before INTA
      do_reset();
      vector_base = 5'h1F;
      raise(8'h02);
      tick();
      tick();
      m_req = eligible();
      check_val("spur_int", int_out, 1'b1);
      do_ack(1'b1, 1'b0);
      check_val("spur_isr", isr, 8'h00);
      check_val("spur_vec", obs_dout, 8'hFF);
      settle(1'b0);

      // Same-cycle specific EOI and acknowledge of IR2
      do_reset();
      vector_base = 5'h08;
      raise(8'h04);
      settle(1'b0);
      raise(8'h02);
      tick();
      tick();
      m_req = eligible();
      check_val("same_int", int_out, 1'b1);
      m_irr   = 8'h04;
      irr_req = m_irr;
      do_ack(1'b0, 1'b1);
      check_val("same_set", isr, 8'h04);
      settle(1'b0);

      // Asynchronous reset while the vector is driven
      raise(8'h01);
      tick();
      tick();
      check_val("mid_int", int_out, 1'b1);
      inta_n = 1'b0;
      repeat (LAT) tick();
      m_irr   = 8'h00;
      irr_req = 8'h00;
      inta_n  = 1'b1;
      repeat (LAT + 1) tick();
      inta_n = 1'b0;
      repeat (LAT) tick();
      check_val("mid_oe", data_oe, 1'b1);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_oe", data_oe, 1'b0);
      check_val("mid_rst_isr", isr, 8'h00);
      check_val("mid_rst_lp", lowest_prio, 3'd7);
      inta_n = 1'b1;
      tick();
      rst_n = 1'b1;
      model_reset();
      tick();

`ifdef PIC_ACK_TIMEOUT_EN
      raise(8'h08);
      tick();
      tick();
      check_val("to_int", int_out, 1'b1);
      inta_n = 1'b0;
      repeat (LAT) tick();
      m_irr   = 8'h00;
      irr_req = 8'h00;
      inta_n  = 1'b1;
      repeat (LAT + 1) tick();
      check_val("to_pre", isr, 8'h08);
      repeat (270) tick();
      check_val("to_isr", isr, 8'h00);
      inta_n = 1'b0;
      repeat (LAT + 1) tick();
      check_val("to_idle_oe", data_oe, 1'b0);
      inta_n = 1'b1;
      repeat (LAT + 1) tick();
      model_reset();
      m_lp = int'(lowest_prio);
`endif

      // Randomized traffic
      do_reset();
      for (int it = 0; it < 300; it++) begin
         case ($urandom_range(0, 4))
            0, 1: raise(8'($urandom & $urandom));
            2: send_ocw({3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7))});
            3: auto_eoi = 1'($urandom);
            default: vector_base = 5'($urandom);
         endcase
         settle(1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
